mul_srv: RTL

- Responder end of the mulit/mulot request interface: the shared 32x32 multiplier server that fmas requests drive.
- Accepts one request per cycle and returns the 64-bit product after a fixed 3-cycle latency.
- Carries a command tag alongside the operands so the requester can match each response to its request.
- Sits beside fmas in the fma top; it replaces the combinational mul0 path with a pipelined unit.

---
 rtl/fma_pkg.sv | 26 ++
 rtl/mul_srv_pp.sv | 16 +
 rtl/mul_srv.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fma_pkg.sv
// Shared types and constants for the fma multiplier path: the mulit/mulot
// request/response structs, the server latency, and the command decode bit.
package fma_pkg;

  typedef struct packed {
    logic        en;
    logic [31:0] req_in_1;
    logic [31:0] req_in_2;
  } mulit;

  typedef struct packed {
    logic [63:0] out;
  } mulot;

  localparam int MUL_LAT        = 3;
  localparam int CMD_SIGNED_BIT = 0;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    logic [31:0] m;
    if (sgn && v[31]) m = ~v + 32'd1;
    else              m = v;
    return m;
  endfunction

endpackage

// File: rtl/mul_srv_pp.sv
// Combinational 16x16 unsigned partial-product array for the 32x32 multiplier.
module mul_srv_pp (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_ll,
  output logic [31:0] o_lh,
  output logic [31:0] o_hl,
  output logic [31:0] o_hh
);

  assign o_ll = {16'd0, i_a[15:0]}  * {16'd0, i_b[15:0]};
  assign o_lh = {16'd0, i_a[15:0]}  * {16'd0, i_b[31:16]};
  assign o_hl = {16'd0, i_a[31:16]} * {16'd0, i_b[15:0]};
  assign o_hh = {16'd0, i_a[31:16]} * {16'd0, i_b[31:16]};

endmodule

// File: rtl/mul_srv.sv
// Pipelined 32x32 multiplier server answering mulit requests with tagged mulot responses.
// Optional freeze input enabled by defining MUL_SRV_HOLD_EN.
module mul_srv
  import fma_pkg::*;
#(
  parameter int TAG_W    = 32,
  parameter bit HOLD_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MUL_SRV_HOLD_EN
  input  logic             hold,
`endif
  input  integer           req_command,
  input  logic [TAG_W-1:0] req_tag,
  input  mulit             muli,
  output mulot             mulo,
  output logic             rsp_valid,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  logic             w_adv;
  logic             w_unused_cmd;
  logic [MUL_LAT:0] r_v;

  logic [31:0]      r_a0, r_b0;
  logic             r_sgn0;
  logic [TAG_W-1:0] r_tag0, r_tag1, r_tag2, r_tag3;
  logic [31:0]      r_ma1, r_mb1;
  logic             r_neg1, r_neg2;
  logic [31:0]      r_ll2, r_lh2, r_hl2, r_hh2;
  logic [63:0]      r_out3;

  logic [31:0]      w_ll, w_lh, w_hl, w_hh;
  logic [32:0]      w_mid;
  logic [63:0]      w_p, w_res;

`ifdef MUL_SRV_HOLD_EN
  assign w_adv = ~hold;
`else
  assign w_adv = 1'b1;
`endif

  assign w_unused_cmd = ^req_command[31:1];

  // Requests are registered on arrival; S1..S3 follow, so rsp_valid rises MUL_LAT edges after sampling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v <= '0;
    end else if (w_adv) begin
      r_v <= {r_v[MUL_LAT-1:0], muli.en};
    end
  end

  // Capture stage and S1: operand magnitudes, result sign, tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a0   <= 32'd0;
      r_b0   <= 32'd0;
      r_sgn0 <= 1'b0;
      r_tag0 <= '0;
      r_ma1  <= 32'd0;
      r_mb1  <= 32'd0;
      r_neg1 <= 1'b0;
      r_tag1 <= '0;
    end else if (w_adv) begin
      if (muli.en) begin
        r_a0   <= muli.req_in_1;
        r_b0   <= muli.req_in_2;
        r_sgn0 <= req_command[CMD_SIGNED_BIT];
        r_tag0 <= req_tag;
      end
      if (r_v[0]) begin
        r_ma1  <= mag32(r_a0, r_sgn0);
        r_mb1  <= mag32(r_b0, r_sgn0);
        r_neg1 <= r_sgn0 & (r_a0[31] ^ r_b0[31]);
        r_tag1 <= r_tag0;
      end
    end
  end

  mul_srv_pp u_pp (
    .i_a  (r_ma1),
    .i_b  (r_mb1),
    .o_ll (w_ll),
    .o_lh (w_lh),
    .o_hl (w_hl),
    .o_hh (w_hh)
  );

  assign w_mid = {1'b0, r_lh2} + {1'b0, r_hl2};
  assign w_p   = {r_hh2, 32'd0} + {15'd0, w_mid, 16'd0} + {32'd0, r_ll2};
  assign w_res = r_neg2 ? (~w_p + 64'd1) : w_p;

  // S2 partial products and S3 recombination into the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ll2  <= 32'd0;
      r_lh2  <= 32'd0;
      r_hl2  <= 32'd0;
      r_hh2  <= 32'd0;
      r_neg2 <= 1'b0;
      r_tag2 <= '0;
      r_out3 <= 64'd0;
      r_tag3 <= '0;
    end else if (w_adv) begin
      if (r_v[1]) begin
        r_ll2  <= w_ll;
        r_lh2  <= w_lh;
        r_hl2  <= w_hl;
        r_hh2  <= w_hh;
        r_neg2 <= r_neg1;
        r_tag2 <= r_tag1;
      end
      if (r_v[2]) begin
        r_out3 <= w_res;
        r_tag3 <= r_tag2;
      end else if (!HOLD_OUT) begin
        r_out3 <= 64'd0;
      end
    end
  end

  assign mulo.out  = r_out3;
  assign rsp_valid = r_v[MUL_LAT];
  assign rsp_tag   = r_tag3;
  assign busy      = |r_v;

endmodule
